timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 83 ++++++++
 tb/tb_timer_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// 64-bit free-running timer with compare match and sticky interrupt; cnt_val updates 1 clock after cnt_en.
// No backpressure: every input is sampled each cycle, halt_ack only freezes the increment.
module timer_counter (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cnt_en,
  input  logic        cnt_clr,
  input  logic        halt_ack,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic        int_en,
  input  logic        int_st_clr,
  output logic [63:0] cnt_val,
  output logic [63:0] cmp_val,
  output logic        int_st,
  output logic        tim_int
);

  logic [63:0] r_cnt;
  logic [63:0] r_cmp;
  logic        r_match_q;
  logic        r_int_st;
  logic        w_match;
  logic        w_match_rise;
  logic        w_wr_cnt_lo;
  logic        w_wr_cnt_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;

  assign w_match      = (r_cnt == r_cmp);
  assign w_match_rise = w_match & ~r_match_q;

  assign w_wr_cnt_lo = wr_en & (wr_sel == 2'd0);
  assign w_wr_cnt_hi = wr_en & (wr_sel == 2'd1);
  assign w_wr_cmp_lo = wr_en & (wr_sel == 2'd2);
  assign w_wr_cmp_hi = wr_en & (wr_sel == 2'd3);

  // Clear beats a counter write, which beats the increment.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= 64'd0;
    end else if (cnt_clr) begin
      r_cnt <= 64'd0;
    end else if (w_wr_cnt_lo) begin
      r_cnt[31:0] <= wr_data;
    end else if (w_wr_cnt_hi) begin
      r_cnt[63:32] <= wr_data;
    end else if (cnt_en && !halt_ack) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cmp <= {64{1'b1}};
    end else begin
      if (w_wr_cmp_lo) r_cmp[31:0]  <= wr_data;
      if (w_wr_cmp_hi) r_cmp[63:32] <= wr_data;
    end
  end

  // Only a fresh match sets status, so a sustained match cannot re-raise it after a clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_match_q <= 1'b0;
      r_int_st  <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (w_match_rise) begin
        r_int_st <= 1'b1;
      end else if (int_st_clr) begin
        r_int_st <= 1'b0;
      end
    end
  end

  assign cnt_val = r_cnt;
  assign cmp_val = r_cmp;
  assign int_st  = r_int_st;
  assign tim_int = r_int_st & int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: vector table for single-cycle behaviour, hand sequences for multi-cycle cases.
module tb_timer_counter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cnt_en;
  logic        cnt_clr;
  logic        halt_ack;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        int_en;
  logic        int_st_clr;
  logic [63:0] cnt_val;
  logic [63:0] cmp_val;
  logic        int_st;
  logic        tim_int;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [63:0] ONES = {64{1'b1}};

  timer_counter dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .halt_ack   (halt_ack),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .int_en     (int_en),
    .int_st_clr (int_st_clr),
    .cnt_val    (cnt_val),
    .cmp_val    (cmp_val),
    .int_st     (int_st),
    .tim_int    (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        halt;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wd;
    logic        ie;
    logic        ic;
    logic [63:0] e_cnt;
    logic [63:0] e_cmp;
    logic        e_st;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic en, logic clr, logic halt, logic we, logic [1:0] sel,
                              logic [31:0] wd, logic ie, logic ic,
                              logic [63:0] e_cnt, logic [63:0] e_cmp, logic e_st);
    vec_t v;
    v.en = en; v.clr = clr; v.halt = halt; v.we = we; v.sel = sel; v.wd = wd;
    v.ie = ie; v.ic = ic; v.e_cnt = e_cnt; v.e_cmp = e_cmp; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic en, input logic clr, input logic halt, input logic we,
                       input logic [1:0] sel, input logic [31:0] wd, input logic ie, input logic ic);
    cnt_en = en; cnt_clr = clr; halt_ack = halt; wr_en = we;
    wr_sel = sel; wr_data = wd; int_en = ie; int_st_clr = ic;
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    drive(0, 0, 0, 0, 2'd0, 32'd0, 0, 0);

    // Vectors run back to back from reset; expected values are the state after each edge.
    vt[0]  = mk(0, 0, 0, 0, 2'd0, 32'h0,          0, 0, 64'd0,                  ONES,                   0);
    vt[1]  = mk(1, 0, 0, 1, 2'd2, 32'h64,         0, 0, 64'd1,                  64'hFFFF_FFFF_0000_0064, 0);
    vt[2]  = mk(1, 0, 0, 1, 2'd0, 32'hFFFF_FFFF,  0, 0, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0064, 0);
    vt[3]  = mk(1, 0, 0, 1, 2'd1, 32'hFFFF_FFFF,  0, 0, ONES,                   64'hFFFF_FFFF_0000_0064, 0);
    vt[4]  = mk(1, 0, 0, 0, 2'd0, 32'h0,          0, 0, 64'd0,                  64'hFFFF_FFFF_0000_0064, 0);
    vt[5]  = mk(1, 0, 0, 0, 2'd0, 32'h0,          0, 0, 64'd1,                  64'hFFFF_FFFF_0000_0064, 0);
    vt[6]  = mk(0, 0, 0, 0, 2'd0, 32'hDEAD_BEEF,  0, 0, 64'd1,                  64'hFFFF_FFFF_0000_0064, 0);
    vt[7]  = mk(1, 1, 0, 1, 2'd0, 32'h1234,       0, 0, 64'd0,                  64'hFFFF_FFFF_0000_0064, 0);
    vt[8]  = mk(0, 0, 0, 1, 2'd3, 32'h0,          0, 0, 64'd0,                  64'h64,                 0);
    vt[9]  = mk(1, 0, 1, 1, 2'd0, 32'h5,          0, 0, 64'd5,                  64'h64,                 0);
    vt[10] = mk(1, 0, 1, 0, 2'd0, 32'h0,          0, 0, 64'd5,                  64'h64,                 0);
    vt[11] = mk(1, 1, 1, 0, 2'd0, 32'h0,          0, 0, 64'd0,                  64'h64,                 0);
    vt[12] = mk(0, 0, 0, 1, 2'd2, 32'd10,         1, 0, 64'd0,                  64'd10,                 0);

    tick;
    chk("rst_cnt", cnt_val, 64'd0);
    chk("rst_cmp", cmp_val, ONES);
    chk("rst_st",  {63'd0, int_st}, 64'd0);
    chk("rst_int", {63'd0, tim_int}, 64'd0);
    tick;
    sys_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].en, vt[i].clr, vt[i].halt, vt[i].we, vt[i].sel, vt[i].wd, vt[i].ie, vt[i].ic);
      tick;
      chk($sformatf("vec%0d_cnt", i), cnt_val, vt[i].e_cnt);
      chk($sformatf("vec%0d_cmp", i), cmp_val, vt[i].e_cmp);
      chk($sformatf("vec%0d_st",  i), {63'd0, int_st},  {63'd0, vt[i].e_st});
      chk($sformatf("vec%0d_int", i), {63'd0, tim_int}, {63'd0, vt[i].e_st & vt[i].ie});
    end

    // Halt freeze then release: cmp = 10, cnt = 0, int_en = 1.
    drive(1, 0, 1, 0, 2'd0, 32'd0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("halt%0d_cnt", i), cnt_val, 64'd0);
    end
    halt_ack = 1'b0;
    repeat (3) tick;
    chk("unhalt_cnt", cnt_val, 64'd3);

    // Count up to the compare value; status follows one clock later.
    repeat (7) tick;
    chk("at10_cnt", cnt_val, 64'd10);
    chk("at10_st",  {63'd0, int_st}, 64'd0);
    halt_ack = 1'b1;
    tick;
    chk("match_cnt", cnt_val, 64'd10);
    chk("match_st",  {63'd0, int_st},  64'd1);
    chk("match_int", {63'd0, tim_int}, 64'd1);
    int_st_clr = 1'b1;
    tick;
    int_st_clr = 1'b0;
    chk("clr_st", {63'd0, int_st}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("hold%0d_st", i), {63'd0, int_st}, 64'd0);
    end

    // Rearm a rising match and collide it with a clear.
    halt_ack = 1'b0;
    tick;
    chk("past_cnt", cnt_val, 64'd11);
    drive(1, 0, 1, 1, 2'd0, 32'd10, 1, 0);
    tick;
    chk("rewr_cnt", cnt_val, 64'd10);
    drive(1, 0, 1, 0, 2'd0, 32'd0, 1, 1);
    tick;
    int_st_clr = 1'b0;
    chk("setwin_st",  {63'd0, int_st},  64'd1);
    chk("setwin_int", {63'd0, tim_int}, 64'd1);
    int_en = 1'b0;
    #1;
    chk("ie0_int", {63'd0, tim_int}, 64'd0);
    chk("ie0_st",  {63'd0, int_st},  64'd1);

    // Asynchronous reset mid-operation with a write in flight.
    drive(1, 0, 1, 1, 2'd0, 32'd7, 1, 0);
    tick;
    chk("pre_rst_cnt", cnt_val, 64'd7);
    chk("pre_rst_st",  {63'd0, int_st}, 64'd1);
    drive(1, 0, 0, 1, 2'd1, 32'h55, 1, 0);
    sys_rst = 1'b1;
    #1;
    chk("arst_cnt", cnt_val, 64'd0);
    chk("arst_cmp", cmp_val, ONES);
    chk("arst_st",  {63'd0, int_st},  64'd0);
    chk("arst_int", {63'd0, tim_int}, 64'd0);
    tick;
    chk("inrst_cnt", cnt_val, 64'd0);
    sys_rst = 1'b0;
    wr_en   = 1'b0;
    tick;
    chk("post_rst_cnt", cnt_val, 64'd1);
    chk("post_rst_cmp", cmp_val, ONES);
    tick;
    chk("post_rst_st", {63'd0, int_st}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
